delay_mem_ctrl: RTL and testbench

Sequencer that owns the delay-line sample memory (memory_mod) for the digital delay effect. On each audio sample strobe it performs one tap read at a programmable distance behind the write pointer, then one write of the new sample. It returns the delayed tap to the effect mix path and tracks fill level so stale or uninitialised memory is never output. It sits between the codec sample strobe/mono mix and memory_mod.

---
 rtl/delay_pkg.sv | 16 +
 rtl/delay_mem_ctrl_if.sv | 33 +++
 rtl/delay_addr_gen.sv | 47 ++++
 rtl/delay_mem_ctrl.sv | 100 ++++++++++
 tb/tb_delay_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
// Shared types and default sizes for the delay-line memory sequencer.
package delay_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/delay_mem_ctrl_if.sv
// Sample-side strobe/tap signals and the memory port of the delay sequencer.
interface delay_mem_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);

    logic              VALID;
    logic [DATA_W-1:0] sample_in;
    logic [ADDR_W-1:0] delay_len;
    logic [DATA_W-1:0] tap_out;
    logic              tap_vld;
    logic              busy;
    logic              overrun;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_d_in;
    logic [DATA_W-1:0] mem_d_out;

    // master: codec/mix side plus the memory's read data
    modport master (
        output VALID, sample_in, delay_len, mem_d_out,
        input  tap_out, tap_vld, busy, overrun,
        input  mem_w_en, mem_w_addr, mem_r_addr, mem_d_in
    );

    modport slave (
        input  VALID, sample_in, delay_len, mem_d_out,
        output tap_out, tap_vld, busy, overrun,
        output mem_w_en, mem_w_addr, mem_r_addr, mem_d_in
    );

endinterface

// File: rtl/delay_addr_gen.sv
// Write pointer, fill level, tap read-address generation and tap gating.
module delay_addr_gen
    import delay_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              commit,
    input  logic [ADDR_W-1:0] len_q,
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tap_en
);

    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] fill_cnt_reg;
    logic [ADDR_W-1:0] rd_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg     <= '0;
            fill_cnt_reg <= '0;
            rd_addr_reg  <= '0;
        end else begin
            if (start) begin
                rd_addr_reg <= wptr_reg - delay_len;
            end
            if (commit) begin
                wptr_reg <= wptr_reg + 1'b1;
                if (fill_cnt_reg != FILL_MAX) begin
                    fill_cnt_reg <= fill_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Uses the fill level before this sample's write is counted.
    assign tap_en  = (len_q != '0) && (fill_cnt_reg >= len_q);
    assign wptr    = wptr_reg;
    assign rd_addr = rd_addr_reg;

endmodule

// File: rtl/delay_mem_ctrl.sv
// Per-sample read-then-write sequencer for the delay-line memory; returns the gated tap.
module delay_mem_ctrl
    import delay_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    delay_mem_ctrl_if.slave bus
);

    localparam int               CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  rd_cnt_reg;
    logic [DATA_W-1:0] samp_q_reg;
    logic [ADDR_W-1:0] len_q_reg;
    logic [ADDR_W-1:0] w_addr_reg;
    logic [DATA_W-1:0] tap_out_reg;
    logic              tap_vld_reg;
    logic              overrun_reg;

    logic              accept;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              tap_en;

    assign accept = (state_reg == IDLE) && bus.VALID;

    delay_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept),
        .delay_len(bus.delay_len),
        .commit   (state_reg == WRITE),
        .len_q    (len_q_reg),
        .wptr     (wptr),
        .rd_addr  (rd_addr),
        .tap_en   (tap_en)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.VALID) state_next = READ;
            READ:    if (rd_cnt_reg == RD_LAST) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rd_cnt_reg  <= '0;
            samp_q_reg  <= '0;
            len_q_reg   <= '0;
            w_addr_reg  <= '0;
            tap_out_reg <= '0;
            tap_vld_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tap_vld_reg <= (state_reg == WRITE);
            if (accept) begin
                samp_q_reg <= bus.sample_in;
                len_q_reg  <= bus.delay_len;
                rd_cnt_reg <= '0;
            end else if (state_reg == READ) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
            // Write address is frozen for the WRITE cycle and then held.
            if ((state_reg == READ) && (state_next == WRITE)) begin
                w_addr_reg <= wptr;
            end
            if (state_reg == WRITE) begin
                tap_out_reg <= tap_en ? bus.mem_d_out : '0;
            end
            if (bus.VALID && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign bus.mem_w_en   = (state_reg == WRITE);
    assign bus.mem_w_addr = w_addr_reg;
    assign bus.mem_d_in   = samp_q_reg;
    assign bus.mem_r_addr = rd_addr;
    assign bus.tap_out    = tap_out_reg;
    assign bus.tap_vld    = tap_vld_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_delay_mem_ctrl.sv
// Randomised self-checking bench for delay_mem_ctrl against a sample-history model.
module tb_delay_mem_ctrl;

    localparam int AW     = 14;
    localparam int DW     = 16;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    delay_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory with one-cycle registered read; unwritten cells return address-dependent junk.
    logic [DW-1:0] mem     [DEPTH];
    logic          written [DEPTH];
    logic [DW-1:0] rd_data = '0;
    always @(posedge clk) begin
        rd_data <= written[bus.mem_r_addr] ? mem[bus.mem_r_addr] : (16'hA5A5 ^ {2'b00, bus.mem_r_addr});
        if (bus.mem_w_en) begin
            mem[bus.mem_w_addr]     <= bus.mem_d_in;
            written[bus.mem_w_addr] <= 1'b1;
        end
    end
    assign bus.mem_d_out = rd_data;

    int errors = 0;
    int checks = 0;

    // Reference model: sample count since reset and the contents each address should hold.
    int            n = 0;
    logic [DW-1:0] model_mem [DEPTH];

    task automatic model_accept(input logic [DW-1:0] d, input logic [AW-1:0] len,
                                output logic [AW-1:0] ra, output logic [AW-1:0] wa,
                                output logic [DW-1:0] tap);
        int fill;
        fill = (n > DEPTH - 1) ? DEPTH - 1 : n;
        ra   = AW'((n - int'(len)) & (DEPTH - 1));
        wa   = AW'(n % DEPTH);
        tap  = (len != 0 && fill >= int'(len)) ? model_mem[ra] : '0;
        model_mem[wa] = d;
        n++;
    endtask

    typedef struct {
        logic          busy1;
        logic [AW-1:0] r_addr;
        int            w_cnt;
        int            w_k;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        int            v_cnt;
        int            v_k;
        logic [DW-1:0] tap;
    } obs_t;

    // One accepted sample: VALID in cycle T, then observe cycles T+1 .. T+RD_LAT+3.
    task automatic run_txn(input logic [DW-1:0] d, input logic [AW-1:0] len, output obs_t o);
        o.busy1 = 1'b0; o.r_addr = '0; o.w_cnt = 0; o.w_k = 0; o.w_addr = '0;
        o.w_data = '0; o.v_cnt = 0; o.v_k = 0; o.tap = '0;
        @(negedge clk);
        bus.VALID = 1'b1; bus.sample_in = d; bus.delay_len = len;
        for (int k = 1; k <= RD_LAT + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.VALID = 1'b0;
                o.busy1   = bus.busy;
                o.r_addr  = bus.mem_r_addr;
            end
            if (bus.mem_w_en) begin
                o.w_cnt++; o.w_k = k; o.w_addr = bus.mem_w_addr; o.w_data = bus.mem_d_in;
            end
            if (bus.tap_vld) begin
                o.v_cnt++; o.v_k = k; o.tap = bus.tap_out;
            end
        end
        $display("txn n=%0d data=%h len=%0d raddr=%h waddr=%h tap=%h vld_k=%0d",
                 n, d, len, o.r_addr, o.w_addr, o.tap, o.v_k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.VALID = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        obs_t o;
        do_reset();
        checks++; if (bus.tap_out !== 16'h0)    begin errors++; $display("FAIL rst_tap_out got=%h exp=0", bus.tap_out); end
        checks++; if (bus.tap_vld !== 1'b0)     begin errors++; $display("FAIL rst_tap_vld got=%b exp=0", bus.tap_vld); end
        checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0)     begin errors++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun); end
        checks++; if (bus.mem_w_en !== 1'b0)    begin errors++; $display("FAIL rst_w_en got=%b exp=0", bus.mem_w_en); end
        checks++; if (bus.mem_w_addr !== 14'h0) begin errors++; $display("FAIL rst_w_addr got=%h exp=0", bus.mem_w_addr); end
        checks++; if (bus.mem_r_addr !== 14'h0) begin errors++; $display("FAIL rst_r_addr got=%h exp=0", bus.mem_r_addr); end
        checks++; if (bus.mem_d_in !== 16'h0)   begin errors++; $display("FAIL rst_d_in got=%h exp=0", bus.mem_d_in); end
        begin
            logic [AW-1:0] ra, wa; logic [DW-1:0] et;
            model_accept(16'h1111, 14'd4, ra, wa, et);
        end
        run_txn(16'h1111, 14'd4, o);
        checks++; if (o.busy1 !== 1'b1)     begin errors++; $display("FAIL first_busy got=%b exp=1", o.busy1); end
        checks++; if (o.r_addr !== 14'h3FFC) begin errors++; $display("FAIL first_r_addr got=%h exp=3ffc", o.r_addr); end
        checks++; if (o.w_cnt != 1 || o.w_k != RD_LAT + 1) begin errors++; $display("FAIL first_w_pulse got cnt=%0d k=%0d exp cnt=1 k=%0d", o.w_cnt, o.w_k, RD_LAT + 1); end
        checks++; if (o.w_addr !== 14'h0 || o.w_data !== 16'h1111) begin errors++; $display("FAIL first_write got addr=%h data=%h exp addr=0 data=1111", o.w_addr, o.w_data); end
        checks++; if (o.v_cnt != 1 || o.v_k != RD_LAT + 2) begin errors++; $display("FAIL first_tap_vld got cnt=%0d k=%0d exp cnt=1 k=%0d", o.v_cnt, o.v_k, RD_LAT + 2); end
        checks++; if (o.tap !== 16'h0)      begin errors++; $display("FAIL first_tap got=%h exp=0", o.tap); end
    endtask

    task automatic test_fill_gate();
        obs_t o; logic [AW-1:0] ra, wa; logic [DW-1:0] et;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            model_accept(16'(i), 14'd4, ra, wa, et);
            run_txn(16'(i), 14'd4, o);
            repeat (10 - (RD_LAT + 4)) @(negedge clk);
            checks++; if (o.v_cnt != 1 || o.tap !== et) begin errors++; $display("FAIL gate_tap i=%0d got=%h cnt=%0d exp=%h", i, o.tap, o.v_cnt, et); end
            checks++; if (o.r_addr !== ra || o.w_addr !== wa) begin errors++; $display("FAIL gate_addr i=%0d got r=%h w=%h exp r=%h w=%h", i, o.r_addr, o.w_addr, ra, wa); end
        end
    endtask

    task automatic test_len_zero();
        obs_t o; logic [AW-1:0] ra, wa; logic [DW-1:0] et, d;
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom_range(1, 16'hFFFF));
            model_accept(d, 14'd0, ra, wa, et);
            run_txn(d, 14'd0, o);
            checks++; if (o.v_cnt != 1 || o.tap !== 16'h0) begin errors++; $display("FAIL len0_tap got=%h cnt=%0d exp=0 cnt=1", o.tap, o.v_cnt); end
            checks++; if (o.w_cnt != 1 || o.w_data !== d || o.w_addr !== wa) begin errors++; $display("FAIL len0_write got cnt=%0d d=%h a=%h exp d=%h a=%h", o.w_cnt, o.w_data, o.w_addr, d, wa); end
        end
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            model_accept(d, 14'd2, ra, wa, et);
            run_txn(d, 14'd2, o);
            checks++; if (o.tap !== et) begin errors++; $display("FAIL len2_tap got=%h exp=%h", o.tap, et); end
        end
    endtask

    task automatic test_overrun();
        obs_t o; logic [AW-1:0] ra, wa; logic [DW-1:0] et;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got=%b exp=0", bus.overrun); end
        @(negedge clk);
        bus.VALID = 1'b1; bus.sample_in = 16'hAAAA; bus.delay_len = 14'd1;
        model_accept(16'hAAAA, 14'd1, ra, wa, et);
        @(negedge clk);
        bus.VALID = 1'b0;
        @(negedge clk);
        bus.VALID = 1'b1; bus.sample_in = 16'hBBBB; bus.delay_len = 14'd2;
        @(negedge clk);
        bus.VALID = 1'b0;
        checks++; if (bus.tap_vld !== 1'b1 || bus.tap_out !== et) begin errors++; $display("FAIL ovr_tap got vld=%b tap=%h exp vld=1 tap=%h", bus.tap_vld, bus.tap_out, et); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovr_dropped_busy got=%b exp=0", bus.busy); end
        repeat (2) @(negedge clk);
        model_accept(16'hCCCC, 14'd1, ra, wa, et);
        run_txn(16'hCCCC, 14'd1, o);
        checks++; if (o.w_addr !== wa) begin errors++; $display("FAIL ovr_wptr got=%h exp=%h", o.w_addr, wa); end
        checks++; if (o.tap !== et) begin errors++; $display("FAIL ovr_next_tap got=%h exp=%h", o.tap, et); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_random();
        obs_t o; logic [AW-1:0] ra, wa, len; logic [DW-1:0] et, d;
        for (int i = 0; i < 150; i++) begin
            d   = 16'($urandom);
            len = 14'($urandom_range(0, 12));
            model_accept(d, len, ra, wa, et);
            run_txn(d, len, o);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++; if (o.v_cnt != 1 || o.v_k != RD_LAT + 2 || o.tap !== et) begin errors++; $display("FAIL rnd_tap i=%0d got=%h cnt=%0d k=%0d exp=%h", i, o.tap, o.v_cnt, o.v_k, et); end
            checks++; if (o.r_addr !== ra || o.w_addr !== wa || o.w_data !== d) begin errors++; $display("FAIL rnd_mem i=%0d got r=%h w=%h d=%h exp r=%h w=%h d=%h", i, o.r_addr, o.w_addr, o.w_data, ra, wa, d); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; logic [AW-1:0] ra, wa; logic [DW-1:0] et;
        int bad_w, bad_v;
        bad_w = 0; bad_v = 0;
        @(negedge clk);
        bus.VALID = 1'b1; bus.sample_in = 16'hDEAD; bus.delay_len = 14'd1;
        @(negedge clk);
        bus.VALID = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.mem_w_en !== 1'b0 || bus.tap_vld !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b w_en=%b vld=%b exp 0", bus.busy, bus.mem_w_en, bus.tap_vld); end
        checks++; if (bus.tap_out !== 16'h0 || bus.mem_r_addr !== 14'h0 || bus.overrun !== 1'b0 || bus.mem_d_in !== 16'h0) begin errors++; $display("FAIL midrst_data got tap=%h r=%h ovr=%b d=%h exp 0", bus.tap_out, bus.mem_r_addr, bus.overrun, bus.mem_d_in); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.mem_w_en) bad_w++;
            if (bus.tap_vld) bad_v++;
        end
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.mem_w_en) bad_w++;
            if (bus.tap_vld) bad_v++;
        end
        checks++; if (bad_w != 0 || bad_v != 0) begin errors++; $display("FAIL midrst_pulses got w=%0d vld=%0d exp 0", bad_w, bad_v); end
        model_accept(16'h4242, 14'd0, ra, wa, et);
        run_txn(16'h4242, 14'd0, o);
        checks++; if (o.w_addr !== 14'h0 || o.w_cnt != 1) begin errors++; $display("FAIL midrst_first_write got a=%h cnt=%0d exp a=0 cnt=1", o.w_addr, o.w_cnt); end
    endtask

    task automatic test_wrap();
        obs_t o; logic [AW-1:0] ra, wa; logic [DW-1:0] et;
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            model_accept(16'(i), 14'd3, ra, wa, et);
            run_txn(16'(i), 14'd3, o);
            checks++; if (o.v_cnt != 1 || o.tap !== et || o.r_addr !== ra) begin errors++; $display("FAIL wrap_txn i=%0d got tap=%h r=%h cnt=%0d exp tap=%h r=%h", i, o.tap, o.r_addr, o.v_cnt, et, ra); end
        end
        checks++; if (o.r_addr !== 14'h3FFE || o.tap !== 16'd16382) begin errors++; $display("FAIL wrap_end got r=%h tap=%h exp r=3ffe tap=%h", o.r_addr, o.tap, 16'd16382); end
        checks++; if (dut.u_addr_gen.fill_cnt_reg !== 14'h3FFF) begin errors++; $display("FAIL wrap_fill_sat got=%h exp=3fff", dut.u_addr_gen.fill_cnt_reg); end
    endtask

    initial begin
        bus.VALID     = 1'b0;
        bus.sample_in = '0;
        bus.delay_len = '0;
        test_reset();
        test_fill_gate();
        test_len_zero();
        test_overrun();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
